// File: rtl/buffer_read_arbiter.sv
// buffer_read_arbiter
// Two-way round-robin arbiter for the single read port of the echo-sample buffer.
// The CPU register reader and the DMA streamer each hold a level request until
// they see their one-cycle response pulse. Only one buffer read is outstanding
// at a time. The FSM runs IDLE -> WAIT -> DONE -> IDLE.
//
// Optional feature (compile-time macro ARB_TIMEOUT_EN):
//   defined   - WAIT is bounded to TIMEOUT_CYCLES cycles. On expiry the winner
//               receives an error response (rsp_err=1, rsp_data=0).
//   undefined - WAIT lasts until buf_data_valid arrives. rsp_err is tied to 0 and
//               the TIMEOUT_CYCLES parameter does not exist.
`timescale 1ns/1ps

module buffer_read_arbiter #(
    parameter int DATA_W = 25
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 256
`endif
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              cpu_req,
    input  logic              dma_req,
    output logic              cpu_rsp_valid,
    output logic              dma_rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              buf_rd_req,
    input  logic              buf_data_valid,
    input  logic [DATA_W-1:0] buf_data_in,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Requester encoding used by rr_ptr and grant: 0 = CPU, 1 = DMA.
    localparam logic SIDE_CPU = 1'b0;

    state_t            state_q, state_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic              grant_q, grant_d;
    logic              buf_rd_req_q, buf_rd_req_d;
    logic              busy_q, busy_d;
    logic              cpu_rsp_valid_q, cpu_rsp_valid_d;
    logic              dma_rsp_valid_q, dma_rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_d;
    logic              pick_dma;

`ifdef ARB_TIMEOUT_EN
    // The counter must be able to hold TIMEOUT_CYCLES-1. The +1 keeps the width
    // at 1 bit or more when TIMEOUT_CYCLES is 1.
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             rsp_err_q;
`endif

    // Winner selection for IDLE. When both sides request, rr_ptr decides. A lone
    // requester always wins.
    always_comb begin
        pick_dma = 1'b0;
        if (cpu_req && dma_req) begin
            pick_dma = rr_ptr_q;
        end else begin
            pick_dma = dma_req;
        end
    end

    // Next-state logic and next values for every registered output.
    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        grant_d         = grant_q;
        cpu_rsp_valid_d = 1'b0;
        dma_rsp_valid_d = 1'b0;
        rsp_data_d      = rsp_data_q;
`ifdef ARB_TIMEOUT_EN
        rsp_err_d       = rsp_err_q;
        // Zero whenever the FSM is not in WAIT. This clears the count on WAIT entry.
        wait_cnt_d      = '0;
`else
        rsp_err_d       = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (cpu_req || dma_req) begin
                    grant_d  = pick_dma;
                    // Next priority goes to the side that did not win.
                    rr_ptr_d = ~pick_dma;
                    state_d  = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // A late-arriving buffer word takes precedence over expiry.
                if (buf_data_valid) begin
                    rsp_data_d      = buf_data_in;
                    rsp_err_d       = 1'b0;
                    cpu_rsp_valid_d = (grant_q == SIDE_CPU);
                    dma_rsp_valid_d = (grant_q != SIDE_CPU);
                    state_d         = ST_DONE;
`ifdef ARB_TIMEOUT_EN
                end else if (wait_cnt_q == CNT_LAST) begin
                    rsp_data_d      = '0;
                    rsp_err_d       = 1'b1;
                    cpu_rsp_valid_d = (grant_q == SIDE_CPU);
                    dma_rsp_valid_d = (grant_q != SIDE_CPU);
                    state_d         = ST_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
`endif
                end
            end

            // The requester drops its request during this cycle. No grant is issued here.
            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // These outputs depend only on the next state. Registering them makes them
        // change on the same edge as the state.
        buf_rd_req_d = (state_d == ST_WAIT);
        busy_d       = (state_d != ST_IDLE);
    end

    // State and output registers. Asynchronous reset returns the block to idle
    // with priority given to the CPU.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q         <= ST_IDLE;
            rr_ptr_q        <= SIDE_CPU;
            grant_q         <= SIDE_CPU;
            buf_rd_req_q    <= 1'b0;
            busy_q          <= 1'b0;
            cpu_rsp_valid_q <= 1'b0;
            dma_rsp_valid_q <= 1'b0;
            rsp_data_q      <= '0;
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            grant_q         <= grant_d;
            buf_rd_req_q    <= buf_rd_req_d;
            busy_q          <= busy_d;
            cpu_rsp_valid_q <= cpu_rsp_valid_d;
            dma_rsp_valid_q <= dma_rsp_valid_d;
            rsp_data_q      <= rsp_data_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // WAIT-cycle counter and the registered error flag.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wait_cnt_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = rsp_err_d;
`endif

    assign cpu_rsp_valid = cpu_rsp_valid_q;
    assign dma_rsp_valid = dma_rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign buf_rd_req    = buf_rd_req_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_buffer_read_arbiter.sv
// Testbench for buffer_read_arbiter.
// The driver tasks push the expected response into a queue. An independent
// monitor pops one entry on each response pulse and compares it with the DUT.
// When compiled with ARB_TIMEOUT_EN, the DUT is built with TIMEOUT_CYCLES = 8.
`timescale 1ns/1ps

module tb_buffer_read_arbiter;

    localparam int DATA_W = 25;

    typedef struct packed {
        logic              is_dma;
        logic [DATA_W-1:0] data;
        logic              err;
    } exp_t;

    logic              aclk = 1'b0;
    logic              areset;
    logic              cpu_req;
    logic              dma_req;
    logic              cpu_rsp_valid;
    logic              dma_rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              buf_rd_req;
    logic              buf_data_valid;
    logic [DATA_W-1:0] buf_data_in;
    logic              busy;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    buffer_read_arbiter #(
        .DATA_W(DATA_W)
`ifdef ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(8)
`endif
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .cpu_req       (cpu_req),
        .dma_req       (dma_req),
        .cpu_rsp_valid (cpu_rsp_valid),
        .dma_rsp_valid (dma_rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .buf_rd_req    (buf_rd_req),
        .buf_data_valid(buf_data_valid),
        .buf_data_in   (buf_data_in),
        .busy          (busy)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: samples 1 ns after each rising edge.
    always @(posedge aclk) begin
        #1;
        if (cpu_rsp_valid === 1'b1 || dma_rsp_valid === 1'b1) begin
            chk("rsp_exclusive", 32'(cpu_rsp_valid & dma_rsp_valid), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got cpu=%b dma=%b data=%h expected no response",
                         cpu_rsp_valid, dma_rsp_valid, rsp_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_who",  32'(dma_rsp_valid), 32'(mon_e.is_dma));
                chk("rsp_data", 32'(rsp_data),      32'(mon_e.data));
                chk("rsp_err",  32'(rsp_err),       32'(mon_e.err));
                $display("rsp %s data=%h err=%b (exp %s data=%h err=%b)",
                         dma_rsp_valid ? "DMA" : "CPU", rsp_data, rsp_err,
                         mon_e.is_dma ? "DMA" : "CPU", mon_e.data, mon_e.err);
            end
        end
    end

    // Runs one complete read transaction. The buffer answers `delay` cycles after
    // the first WAIT cycle. After the pulse, reqs stay high when hold=1.
    task automatic do_txn(input logic c, input logic d, input logic exp_dma,
                          input logic [DATA_W-1:0] data, input int delay,
                          input logic drop_early, input logic hold);
        exp_t e;
        @(negedge aclk);
        chk("rd_req_idle", 32'(buf_rd_req), 32'd0);
        cpu_req = c;
        dma_req = d;
        e.is_dma = exp_dma;
        e.data   = data;
        e.err    = 1'b0;
        exp_q.push_back(e);
        @(negedge aclk);
        chk("rd_req_wait", 32'({buf_rd_req, busy}), 32'h3);
        if (drop_early) begin
            cpu_req = 1'b0;
            dma_req = 1'b0;
        end
        repeat (delay) @(negedge aclk);
        buf_data_valid = 1'b1;
        buf_data_in    = data;
        @(negedge aclk);
        buf_data_valid = 1'b0;
        buf_data_in    = 25'h0F0F0F0;
        chk("rsp_pulse", 32'(exp_dma ? dma_rsp_valid : cpu_rsp_valid), 32'd1);
        chk("rd_req_done", 32'({buf_rd_req, busy}), 32'h1);
        if (!hold) begin
            cpu_req = 1'b0;
            dma_req = 1'b0;
        end
    endtask

    initial begin
        areset         = 1'b1;
        cpu_req        = 1'b0;
        dma_req        = 1'b0;
        buf_data_valid = 1'b0;
        buf_data_in    = '0;
        repeat (2) @(negedge aclk);
        chk("reset_outputs", 32'({cpu_rsp_valid, dma_rsp_valid, rsp_err, buf_rd_req, busy, |rsp_data}), 32'd0);
        areset = 1'b0;

        // CPU only. The buffer answers 3 cycles after the first WAIT cycle.
        do_txn(1'b1, 1'b0, 1'b0, 25'h1ABCDEF, 3, 1'b0, 1'b0);

        // Reset while IDLE after a CPU grant. Both sides then request, and CPU must win.
        @(negedge aclk);
        areset = 1'b1;
        @(negedge aclk);
        chk("reset_clears_data", 32'(rsp_data), 32'd0);
        areset = 1'b0;

        // Both requests held for six transactions. Grants must alternate.
        do_txn(1'b1, 1'b1, 1'b0, 25'h0000001, 1, 1'b0, 1'b1);
        do_txn(1'b1, 1'b1, 1'b1, 25'h0000002, 0, 1'b0, 1'b1);
        do_txn(1'b1, 1'b1, 1'b0, 25'h1FFFFFF, 2, 1'b0, 1'b1);
        do_txn(1'b1, 1'b1, 1'b1, 25'h0AAAAAA, 0, 1'b0, 1'b1);
        do_txn(1'b1, 1'b1, 1'b0, 25'h1555555, 4, 1'b0, 1'b1);
        do_txn(1'b1, 1'b1, 1'b1, 25'h0123456, 1, 1'b0, 1'b0);

        // DMA alone twice, then both sides. CPU must win.
        do_txn(1'b0, 1'b1, 1'b1, 25'h0C0FFEE, 2, 1'b0, 1'b0);
        do_txn(1'b0, 1'b1, 1'b1, 25'h0BEEF00, 0, 1'b0, 1'b0);
        do_txn(1'b1, 1'b1, 1'b0, 25'h1234567, 1, 1'b0, 1'b0);

        // buf_data_valid pulsed in IDLE. There must be no response, and the data must hold.
        @(negedge aclk);
        buf_data_valid = 1'b1;
        buf_data_in    = 25'h0DEAD00;
        @(negedge aclk);
        buf_data_valid = 1'b0;
        repeat (2) @(negedge aclk);
        chk("idle_valid_ignored", 32'({cpu_rsp_valid, dma_rsp_valid, buf_rd_req, busy}), 32'd0);
        chk("rsp_data_hold", 32'(rsp_data), 32'h1234567);

        // The granted request is dropped during WAIT. The transaction still completes.
        do_txn(1'b0, 1'b1, 1'b1, 25'h0777777, 2, 1'b1, 1'b0);

        // Asynchronous reset in the middle of WAIT. Outputs must clear immediately.
        @(negedge aclk);
        cpu_req = 1'b1;
        @(negedge aclk);
        chk("midwait_rd_req", 32'(buf_rd_req), 32'd1);
        #1 areset = 1'b1;
        #1;
        chk("midwait_reset_outputs", 32'({cpu_rsp_valid, dma_rsp_valid, rsp_err, buf_rd_req, busy, |rsp_data}), 32'd0);
        cpu_req = 1'b0;
        @(negedge aclk);
        areset = 1'b0;
        do_txn(1'b1, 1'b1, 1'b0, 25'h0ABCDEF, 0, 1'b0, 1'b0);

        // The buffer never answers.
`ifdef ARB_TIMEOUT_EN
        begin
            exp_t e;
            @(negedge aclk);
            e.is_dma = 1'b0;
            e.data   = '0;
            e.err    = 1'b1;
            exp_q.push_back(e);
            cpu_req = 1'b1;
            @(negedge aclk);
            chk("timeout_rd_req", 32'(buf_rd_req), 32'd1);
            repeat (7) begin
                @(negedge aclk);
                chk("timeout_early", 32'(cpu_rsp_valid), 32'd0);
            end
            @(negedge aclk);
            chk("timeout_pulse", 32'({cpu_rsp_valid, buf_rd_req}), 32'h2);
            cpu_req = 1'b0;
        end
`else
        @(negedge aclk);
        cpu_req = 1'b1;
        repeat (120) @(negedge aclk);
        chk("no_timeout_busy", 32'({busy, buf_rd_req, cpu_rsp_valid}), 32'h6);
        areset  = 1'b1;
        cpu_req = 1'b0;
        @(negedge aclk);
        areset = 1'b0;
`endif

        repeat (3) @(negedge aclk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guards against a hang.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected simulation end");
        $fatal(1, "watchdog expired");
    end

endmodule
